// File: rtl/reg_wb_pkg.sv
// Shared constants and state encoding for the register-file writeback arbiter.
package reg_wb_pkg;

    localparam int unsigned REG_ADDR_WIDTH = 5;
    localparam int unsigned REG_DATA_WIDTH = 32;
    localparam int unsigned REG_DEPTH      = 32;

    typedef logic [0:0] wb_state_t;

    localparam wb_state_t INIT = 1'b0;
    localparam wb_state_t RUN  = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the tie-break pointer moves only when a grant is taken.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // Set when port 1 should win the next tie.
    logic favour1_q;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = favour1_q ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            favour1_q <= 1'b0;
        end else if (advance && (gnt != 2'b00)) begin
            favour1_q <= gnt[0];
        end
    end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Register-file writeback arbiter: clears every register after reset, then merges the ALU and
// load writeback ports into one registered write port with round-robin fairness.
module reg_wb_arbiter
    import reg_wb_pkg::*;
#(
    parameter int unsigned reg_addr_width = REG_ADDR_WIDTH,
    parameter int unsigned reg_data_width = REG_DATA_WIDTH,
    parameter int unsigned reg_depth      = REG_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req0_valid,
    input  logic [reg_addr_width-1:0] req0_addr,
    input  logic [reg_data_width-1:0] req0_data,
    output logic                      req0_ready,
    input  logic                      req1_valid,
    input  logic [reg_addr_width-1:0] req1_addr,
    input  logic [reg_data_width-1:0] req1_data,
    output logic                      req1_ready,
    output logic [reg_addr_width-1:0] wr_addr,
    output logic [reg_data_width-1:0] wr_data,
    output logic                      write_back_en,
    output logic                      init_done
);

    // One extra count value marks the cycle after the last clear write.
    localparam int unsigned cnt_width = $clog2(reg_depth + 1);

    wb_state_t                 state_q;
    logic [cnt_width-1:0]      count_q;
    logic                      init_done_q;
    logic                      wbe_q;
    logic [reg_addr_width-1:0] wr_addr_q;
    logic [reg_data_width-1:0] wr_data_q;

    logic                      run;
    logic [1:0]                req;
    logic [1:0]                gnt;
    logic                      handshake;
    logic [reg_addr_width-1:0] sel_addr;
    logic [reg_data_width-1:0] sel_data;
    logic                      sel_writes;

    assign run = (state_q == RUN);
    assign req = {req1_valid, req0_valid} & {2{run}};

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .advance (run),
        .gnt     (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];

    always_comb begin
        handshake  = |gnt;
        sel_addr   = gnt[1] ? req1_addr : req0_addr;
        sel_data   = gnt[1] ? req1_data : req0_data;
        // x0 is hardwired to zero: accept the write but never strobe it.
        sel_writes = handshake && (sel_addr != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT;
            count_q     <= '0;
            init_done_q <= 1'b0;
            wbe_q       <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            case (state_q)
                INIT: begin
                    if (count_q == cnt_width'(reg_depth)) begin
                        state_q     <= RUN;
                        init_done_q <= 1'b1;
                        wbe_q       <= 1'b0;
                    end else begin
                        wbe_q     <= 1'b1;
                        wr_addr_q <= reg_addr_width'(count_q);
                        wr_data_q <= '0;
                        count_q   <= count_q + cnt_width'(1);
                    end
                end
                default: begin
                    wbe_q <= sel_writes;
                    if (sel_writes) begin
                        wr_addr_q <= sel_addr;
                        wr_data_q <= sel_data;
                    end
                end
            endcase
        end
    end

    assign write_back_en = wbe_q;
    assign wr_addr       = wr_addr_q;
    assign wr_data       = wr_data_q;
    assign init_done     = init_done_q;

    // Requesters must hold their request stable until it is accepted.
    req0_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (req0_valid && !req0_ready) |=>
            (req0_valid && $stable(req0_addr) && $stable(req0_data)));

    req1_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (req1_valid && !req1_ready) |=>
            (req1_valid && $stable(req1_addr) && $stable(req1_data)));

endmodule

// File: doc/reg_wb_arbiter.md
REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 The block SHALL have parameter reg_addr_width, default 5, register address width.
REQ-002 The block SHALL have parameter reg_data_width, default 32, register data width.
REQ-003 The block SHALL have parameter reg_depth, default 32, number of registers to clear at init.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset, with ports as listed below.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port req0_valid, input, 1 bit: port 0 (ALU writeback) has a write pending.
REQ-008 The block SHALL have port req0_addr, input, reg_addr_width bits: port 0 destination register.
REQ-009 The block SHALL have port req0_data, input, reg_data_width bits: port 0 write data.
REQ-010 The block SHALL have port req0_ready, output, 1 bit: port 0 write accepted this cycle.
REQ-011 The block SHALL have ports req1_valid/req1_addr/req1_data/req1_ready with the same widths and meanings as port 0, for load writeback.
REQ-012 The block SHALL have port wr_addr, output, reg_addr_width bits: register file write address.
REQ-013 The block SHALL have port wr_data, output, reg_data_width bits: register file write data.
REQ-014 The block SHALL have port write_back_en, output, 1 bit: register file write strobe.
REQ-015 The block SHALL have port init_done, output, 1 bit: clear sequence complete and arbitration active.

Function
REQ-016 The block SHALL implement FSM states INIT and RUN; reset enters INIT with clear counter = 0.
REQ-017 In INIT, each cycle the block SHALL register write_back_en=1, wr_addr=counter, wr_data=0, then increment the counter.
REQ-018 When the counter reaches reg_depth-1, the block SHALL transition to RUN next cycle and set init_done=1, which stays 1 until reset.
REQ-019 In INIT, the block SHALL hold req0_ready=req1_ready=0 regardless of valid.
REQ-020 In RUN, the block SHALL grant at most one port per cycle; handshake = valid && ready; ready is combinational from valid and the priority pointer.
REQ-021 With one port valid, the block SHALL grant that port; with both valid, it SHALL grant the port not granted most recently; the pointer updates only on a grant.
REQ-022 After reset, the priority pointer SHALL favour port 0.
REQ-023 The block SHALL present an accepted write on wr_addr/wr_data/write_back_en in the cycle after the handshake (1-cycle latency, registered outputs).
REQ-024 In a cycle with no handshake, the block SHALL deassert write_back_en; wr_addr/wr_data hold their last value.
REQ-025 The block SHALL accept an address-0 write (ready=1) but SHALL NOT assert write_back_en for it (x0 stays 0).
REQ-026 For two valid requests to the same address in the same cycle, the block SHALL write them in grant order; the later grant wins in the register file.
REQ-027 Requesters SHALL hold valid, addr and data stable until ready; the block SHALL flag any violation via an assertion only.

Reset
REQ-028 On rst_n=0, the block SHALL immediately set write_back_en=0, wr_addr=0, wr_data=0, init_done=0, state=INIT, counter=0, and pointer=port 0.
REQ-029 The block SHALL make both ready outputs 0 during reset.
REQ-030 A reset mid-INIT or mid-RUN SHALL abort any in-flight write, drop any in-flight grant, and restart the full clear sequence.

Structure
REQ-031 Package reg_wb_pkg SHALL hold the state enum (INIT, RUN) and the default width/depth constants.
REQ-032 The 2-way round-robin grant logic SHALL be the sub-module rr_arbiter2 (inputs req[1:0], advance; output gnt[1:0]).

Verification
REQ-033 Verification SHALL show: after reset release, 32 consecutive cycles with write_back_en=1, wr_addr 0..31, wr_data=0, then init_done=1 on the next cycle.
REQ-034 Verification SHALL show: in RUN, req0 only (addr 5, data 0xAA) -> req0_ready=1, and next cycle write_back_en=1, wr_addr=5, wr_data=0xAA.
REQ-035 Verification SHALL show: both valid for 4 cycles (addr 3 and addr 4) -> grants alternate 0,1,0,1 with one write per cycle.
REQ-036 Verification SHALL show: req1 addr 0, data 0xFF -> req1_ready=1 and write_back_en stays 0.
REQ-037 Verification SHALL show: rst_n asserted at clear address 10 -> outputs zero at once; on release, clearing restarts from address 0.
REQ-038 Verification SHALL show: valid asserted during INIT -> ready=0 until init_done=1, then granted on the first RUN cycle.
